// File: rtl/iq_ctrl_param.sv
// rtl/iq_ctrl_param.sv - parametrised instruction-queue controller with age-matrix issue select
//
// Purpose: tracks DEPTH queue entries (valid bits plus a pairwise age matrix),
// grants free slots to NLOAD dispatch ports and issues the oldest operand-ready
// entries to NISSUE execution units, all with zero-latency combinational grants.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous active-high; empties the queue and masks all grants
//   iq_loads     [NLOAD]        dispatch port p presents an instruction
//   exe_ready    [NISSUE]       execution unit u can accept an instruction
//   ops_ready    [DEPTH]        entry i has all operands available
//   flush        [DEPTH]        invalidate entry i at the next edge
//   load         [DEPTH*NLOAD]  bit i*NLOAD+p: port p writes entry i
//   load_accept  [NLOAD]        port p received a slot this cycle
//   issue        [DEPTH*NISSUE] bit i*NISSUE+u: entry i issues to unit u
//   valid        [DEPTH]        registered entry-valid bits
//   count        [CW]           registered popcount of valid
//   full         1              registered, count == DEPTH
module iq_ctrl_param #(
  parameter int DEPTH  = 4,
  parameter int NLOAD  = 2,
  parameter int NISSUE = 2,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NLOAD-1:0]         iq_loads,
  input  logic [NISSUE-1:0]        exe_ready,
  input  logic [DEPTH-1:0]         ops_ready,
  input  logic [DEPTH-1:0]         flush,
  output logic [DEPTH*NLOAD-1:0]   load,
  output logic [NLOAD-1:0]         load_accept,
  output logic [DEPTH*NISSUE-1:0]  issue,
  output logic [DEPTH-1:0]         valid,
  output logic [CW-1:0]            count,
  output logic                     full
);

  // Upper-triangle age bits, packed row by row: (0,1),(0,2)..(0,D-1),(1,2)..
  localparam int NA = DEPTH * (DEPTH - 1) / 2;

  function automatic int idx(input int i, input int j);
    return i * DEPTH - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [NA-1:0]    age_q, age_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;

  logic [DEPTH-1:0] loaded;
  logic [DEPTH-1:0] issued;
  logic [DEPTH-1:0] survive;

  // Load grant: ports in index order each take the lowest free, unflushed slot.
  always_comb begin
    logic [DEPTH-1:0] avail;
    logic             found;
    load        = '0;
    load_accept = '0;
    loaded      = '0;
    avail       = ~valid_q & ~flush;
    found       = 1'b0;
    for (int p = 0; p < NLOAD; p++) begin
      found = 1'b0;
      if (iq_loads[p] && !reset) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!found && avail[i]) begin
            load[i*NLOAD+p] = 1'b1;
            load_accept[p]  = 1'b1;
            loaded[i]       = 1'b1;
            avail[i]        = 1'b0;
            found           = 1'b1;
          end
        end
      end
    end
  end

  // Issue select: each ready unit takes the oldest remaining eligible entry.
  // An entry is oldest when it is older than every other remaining eligible one.
  always_comb begin
    logic [DEPTH-1:0] elig;
    logic             picked;
    logic             is_old;
    logic             older_ij;
    issue    = '0;
    issued   = '0;
    elig     = valid_q & ops_ready & ~flush;
    picked   = 1'b0;
    is_old   = 1'b0;
    older_ij = 1'b0;
    for (int u = 0; u < NISSUE; u++) begin
      picked = 1'b0;
      if (exe_ready[u] && !reset) begin
        for (int i = 0; i < DEPTH; i++) begin
          is_old = elig[i];
          for (int j = 0; j < DEPTH; j++) begin
            if (j != i) begin
              // Both entries are valid here, so the lower-triangle relation
              // is simply the complement of the stored upper-triangle bit.
              older_ij = (i < j) ? age_q[idx(i, j)] : ~age_q[idx(j, i)];
              if (elig[j] && !older_ij) begin
                is_old = 1'b0;
              end
            end
          end
          if (is_old && !picked) begin
            issue[i*NISSUE+u] = 1'b1;
            issued[i]         = 1'b1;
            elig[i]           = 1'b0;
            picked            = 1'b1;
          end
        end
      end
    end
  end

  // Next-state: valid, age matrix, occupancy.
  always_comb begin
    survive = valid_q & ~issued & ~flush;
    valid_d = survive | (loaded & ~flush);
    age_d   = '0;
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = i + 1; j < DEPTH; j++) begin
        if (!valid_d[i]) begin
          age_d[idx(i, j)] = 1'b0;
        end else if (!valid_d[j]) begin
          age_d[idx(i, j)] = 1'b1;
        end else if (survive[i] && survive[j]) begin
          age_d[idx(i, j)] = age_q[idx(i, j)];
        end else if (survive[i]) begin
          age_d[idx(i, j)] = 1'b1;
        end else if (survive[j]) begin
          age_d[idx(i, j)] = 1'b0;
        end else begin
          // Both loaded: lower ports always receive lower entry indices, so
          // entry i (i<j) came from the lower, hence older, port.
          age_d[idx(i, j)] = 1'b1;
        end
      end
      count_d = count_d + CW'(valid_d[i]);
    end
    full_d = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      age_q   <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      age_q   <= age_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign valid = valid_q;
  assign count = count_q;
  assign full  = full_q;

endmodule

// File: doc/iq_ctrl_param.md
Name: iq_ctrl_param

Overview:
- Parametrised instruction-queue controller: DEPTH entries, NLOAD dispatch ports, NISSUE execution units.
- Tracks valid bits and a pairwise age matrix.
- Grants queue slots to dispatch ports and issues the oldest operand-ready entries to execution units.
- Supports per-entry flush, back-pressure and an occupancy count.
- Sits between the dispatch stage and the execution-unit arbiters.

Parameters:
- DEPTH, 4, number of queue entries (2..16)
- NLOAD, 2, dispatch ports per cycle (1..DEPTH)
- NISSUE, 2, execution units per cycle (1..DEPTH)
- CW, $clog2(DEPTH+1), width of the occupancy count

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears queue state
- iq_loads  input  NLOAD  bit p: dispatch port p presents an instruction
- exe_ready  input  NISSUE  bit u: execution unit u can accept an instruction
- ops_ready  input  DEPTH  bit i: entry i has all operands available
- flush  input  DEPTH  bit i: invalidate entry i at the next edge
- load  output  DEPTH*NLOAD  bit [i*NLOAD+p]: port p writes entry i
- load_accept  output  NLOAD  bit p: port p received a slot this cycle
- issue  output  DEPTH*NISSUE  bit [i*NISSUE+u]: entry i issues to unit u
- valid  output  DEPTH  registered entry-valid bits
- count  output  CW  registered popcount of valid
- full  output  1  registered, count==DEPTH

Behaviour:
- State:
  - valid[DEPTH].
  - age[i][j] for i<j, DEPTH*(DEPTH-1)/2 bits. age[i][j]=1 means entry i is valid and either entry j is invalid or entry i is older than entry j.
  - Reset: valid=0, age=0, count=0, full=0.
- Reset masking: while reset=1, all of load, load_accept and issue are 0. Reset overrides every other input at the edge.
- Loads (combinational, zero latency):
  - Candidate slots: entries with valid=0 and flush=0.
  - Ports are served in index order, 0 first. Each requesting port p takes the lowest-indexed candidate not already taken by a lower port.
  - A port with no remaining candidate gets load_accept[p]=0 and must retry. Non-requesting ports consume no slot.
  - Each entry is loaded by at most one port.
  - load_accept[p] = OR over i of load[i][p].
- Issue (combinational, zero latency):
  - Eligible entries: valid & ops_ready & ~flush.
  - Oldest eligible entry means the entry i with no other eligible entry older than it, per the age matrix.
  - Units are served in index order. Unit u with exe_ready[u]=1 takes the oldest eligible entry not taken by a lower unit.
  - A unit with exe_ready=0 takes nothing, and the next ready unit takes what it would have taken.
  - At most one unit per entry; at most one entry per unit.
- Next valid: nv[i] = ~flush[i] & ((valid[i] & ~issued[i]) | loaded[i]).
  - Entries are never loaded and issued in the same cycle, because loads target only invalid entries.
- Next age[i][j], i<j:
  - nv[i]=0: 0.
  - nv[i]=1, nv[j]=0: 1.
  - Both survivors (valid, not issued, not flushed): unchanged age[i][j].
  - i survivor, j loaded: 1. i loaded, j survivor: 0.
  - Both loaded this cycle: 1 iff the loading port index of i is less than that of j. Lower port is older.
- count and full: computed from nv and registered. They reflect valid exactly, with the same one-cycle latency.
- Invariants, checked every cycle:
  - age[i][j] implies valid[i].
  - valid[i] & ~valid[j] implies age[i][j]=1 (i<j); valid[j] & ~valid[i] implies age[i][j]=0.
  - Age relation restricted to valid entries is a strict total order (transitive, no cycles).
  - popcount(load_accept) <= DEPTH - popcount(valid | flush).
  - At most one issue per unit and at most one per entry.
- Simultaneous events:
  - Flush of an entry that is also ready: no issue from it.
  - Flush of a free entry: the entry is not offered for loading that cycle.
  - Flush, load and issue to different entries in the same cycle are independent.
  - Full queue: all load_accept=0. Empty queue: no issue.
- Reset mid-operation: the queue is emptied at the next edge regardless of in-flight loads or issues. No grant is visible while reset is high.

Test Plan (DEPTH=4, NLOAD=2, NISSUE=2):
- Reset, then iq_loads=11 -> load entry0<-p0, entry1<-p1, load_accept=11; next cycle valid=1100, count=2, age[0][1]=1.
- Fill the queue over 2 cycles, then iq_loads=11 -> load_accept=00, full=1; flush=0010 -> next cycle valid=1101, count=3, and entry2 is granted to p0 on the following load.
- Entries loaded in order 2,0,3; ops_ready=1111, exe_ready=11 -> issue entry2->u0, entry0->u1; next valid leaves only entry3.
- Oldest entry ready with exe_ready=10 -> unit0 takes the oldest; exe_ready=01 -> unit1 takes the oldest.
- Oldest entry ready but flush on it -> no issue from it, the next-oldest issues, and it is invalid next cycle.
- Assert reset with a full queue and iq_loads=11, exe_ready=11 -> load/issue=0 in that cycle; next cycle valid=0000, count=0, full=0, age=0.
